// File: rtl/pattern_scan_pkg.sv
// pattern_scan_pkg: shared widths and controller state encoding for the pattern scanner
package pattern_scan_pkg;
    localparam int BYTE_W = 8;
    localparam int CNT_W = 4;
    localparam int WIN_W = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, REPORT = 2'd2} state_t;
endpackage

// File: rtl/pattern_scan_if.sv
// pattern_scan_if: two requester handshakes plus the result bus of pattern_scan_ctrl
interface pattern_scan_if;
    import pattern_scan_pkg::*;
    logic req0_valid, req1_valid;
    logic [BYTE_W-1:0] req0_data, req1_data;
    logic req0_ready, req1_ready;
    logic done, done_id;
    logic [CNT_W-1:0] match_cnt;
    modport master(
        output req0_valid, req1_valid, req0_data, req1_data,
        input req0_ready, req1_ready, done, done_id, match_cnt
    );
    modport slave(
        input req0_valid, req1_valid, req0_data, req1_data,
        output req0_ready, req1_ready, done, done_id, match_cnt
    );
endinterface

// File: rtl/serial_pattern_match.sv
// serial_pattern_match: sliding-window serial detector with saturating match counter
module serial_pattern_match
    import pattern_scan_pkg::*;
#(
    parameter logic [WIN_W-1:0] PATTERN = 4'b1101,
    parameter bit OVERLAP = 1'b1
) (
    input logic clk,
    input logic clr,
    input logic clear,
    input logic bit_valid,
    input logic bit_in,
    output logic [CNT_W-1:0] count
);
    logic [WIN_W-1:0] win, cand;
    logic [2:0] seen;
    logic hit, flush;

    // seen counts earlier bits of this byte, saturating once the window is full
    assign cand = {win[WIN_W-2:0], bit_in};
    assign hit = bit_valid && seen == 3'(WIN_W - 1) && cand == PATTERN;
    assign flush = hit && !OVERLAP;

    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            win <= '0;
            seen <= '0;
            count <= '0;
        end else if (clear) begin
            win <= '0;
            seen <= '0;
            count <= '0;
        end else if (bit_valid) begin
            win <= flush ? '0 : cand;
            seen <= flush ? '0 : (seen == 3'(WIN_W - 1)) ? seen : seen + 3'd1;
            count <= count + CNT_W'(hit && count != '1);
        end
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: round-robin grant of one byte, serial scan for PATTERN, one-cycle result report
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter logic [WIN_W-1:0] PATTERN = 4'b1101,
    parameter bit OVERLAP = 1'b1
) (
    input logic clk,
    input logic clr,
    pattern_scan_if.slave bus
);
    state_t state, nxt;
    logic ptr, gid, id_q, any, gnt, take, shifting, rep;
    logic [BYTE_W-1:0] sr;
    logic [2:0] bcnt;
    logic [CNT_W-1:0] cnt, cnt_q;

    assign any = bus.req0_valid | bus.req1_valid;
    assign gnt = (bus.req0_valid & bus.req1_valid) ? ptr : bus.req1_valid;
    assign take = (state == IDLE) & any;
    assign shifting = state == SHIFT;
    assign rep = state == REPORT;

    // result outputs show the live count while reporting, then hold the captured copy
    always_comb begin
        nxt = take ? SHIFT : shifting ? (&bcnt ? REPORT : SHIFT) : IDLE;
        bus.req0_ready = clr & take & ~gnt;
        bus.req1_ready = clr & take & gnt;
        bus.done = rep;
        bus.done_id = rep ? gid : id_q;
        bus.match_cnt = rep ? cnt : cnt_q;
    end

    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            state <= IDLE;
            ptr <= 1'b0;
            gid <= 1'b0;
            id_q <= 1'b0;
            sr <= '0;
            bcnt <= '0;
            cnt_q <= '0;
        end else begin
            state <= nxt;
            if (take) begin
                sr <= gnt ? bus.req1_data : bus.req0_data;
                gid <= gnt;
                ptr <= ~gnt;
                bcnt <= '0;
            end else if (shifting) begin
                sr <= sr << 1;
                bcnt <= bcnt + 3'd1;
            end
            if (rep) begin
                id_q <= gid;
                cnt_q <= cnt;
            end
        end

    serial_pattern_match #(.PATTERN(PATTERN), .OVERLAP(OVERLAP)) u_match (
        .clk(clk),
        .clr(clr),
        .clear(take),
        .bit_valid(shifting),
        .bit_in(sr[BYTE_W-1]),
        .count(cnt)
    );
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: vector table, directed corner cases and random traffic against a timeline model
module tb_pattern_scan_ctrl;
    localparam logic [7:0] PAT = 8'h0D;

    typedef struct {
        bit v0, v1;
        logic [7:0] d0, d1;
        bit id;
        int c1, c0;
    } vec_t;

    typedef struct {
        int due;
        bit id;
        logic [3:0] c1, c0;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int checks = 0;
    int failures = 0;

    pattern_scan_if b1();
    pattern_scan_if b0();

    assign b0.req0_valid = b1.req0_valid;
    assign b0.req1_valid = b1.req1_valid;
    assign b0.req0_data = b1.req0_data;
    assign b0.req1_data = b1.req1_data;

    pattern_scan_ctrl #(.PATTERN(4'b1101), .OVERLAP(1'b1)) dut1 (.clk(clk), .clr(clr), .bus(b1.slave));
    pattern_scan_ctrl #(.PATTERN(4'b1101), .OVERLAP(1'b0)) dut0 (.clk(clk), .clr(clr), .bus(b0.slave));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // count windows of four consecutive bits (MSB first) equal to the pattern
    function automatic logic [3:0] model(input logic [7:0] d, input bit ov);
        int c = 0;
        int last = -1;
        for (int i = 3; i < 8; i++)
            if (i - 3 > last && ((d >> (7 - i)) & 8'h0F) == PAT) begin
                c++;
                if (!ov) last = i;
            end
        return 4'(c > 15 ? 15 : c);
    endfunction

    task automatic put(input bit v0, input bit v1, input logic [7:0] d0, input logic [7:0] d1);
        b1.req0_valid = v0;
        b1.req1_valid = v1;
        b1.req0_data = d0;
        b1.req1_data = d1;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
    endtask

    // timeline model: a grant is legal 10 cycles after the previous one; result follows 9 cycles later
    int cyc, lg;
    bit ptr_m, pdone, hid;
    logic [3:0] hc1, hc0;
    exp_t q[$];

    always @(negedge clk) begin : mon
        bit tk, g;
        logic [1:0] er;
        exp_t e;
        if (!clr) begin
            chk("rst_outputs", {b1.req1_ready, b1.req0_ready, b1.done, b1.done_id, b1.match_cnt, b0.match_cnt}, 0);
            q.delete();
            cyc = 0;
            lg = -100;
            ptr_m = 1'b0;
            pdone = 1'b0;
            hid = 1'b0;
            hc1 = '0;
            hc0 = '0;
        end else begin
            cyc++;
            tk = (b1.req0_valid | b1.req1_valid) && cyc >= lg + 10;
            g = (b1.req0_valid && b1.req1_valid) ? ptr_m : b1.req1_valid;
            er = tk ? (g ? 2'b10 : 2'b01) : 2'b00;
            chk("ready", {b0.req1_ready, b0.req0_ready, b1.req1_ready, b1.req0_ready}, {er, er});
            if (tk) begin
                e.due = cyc + 9;
                e.id = g;
                e.c1 = model(g ? b1.req1_data : b1.req0_data, 1'b1);
                e.c0 = model(g ? b1.req1_data : b1.req0_data, 1'b0);
                q.push_back(e);
                ptr_m = !g;
                lg = cyc;
            end
            chk("done_twice", pdone & b1.done, 0);
            pdone = b1.done;
            if (q.size() > 0 && q[0].due == cyc) begin
                hid = q[0].id;
                hc1 = q[0].c1;
                hc0 = q[0].c0;
                void'(q.pop_front());
                chk("done", {b0.done, b1.done}, 2'b11);
            end else
                chk("done", {b0.done, b1.done}, 2'b00);
            chk("done_id", {b0.done_id, b1.done_id}, {hid, hid});
            chk("cnt_ov1", b1.match_cnt, hc1);
            chk("cnt_ov0", b0.match_cnt, hc0);
        end
    end

    task automatic run_one(input vec_t v, input bit rnd, input string nm);
        put(v.v0, v.v1, v.d0, v.d1);
        @(negedge clk);
        chk({nm, "_ready"}, {b1.req1_ready, b1.req0_ready}, v.id ? 2'b10 : 2'b01);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (rnd) put(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            else put(v.v0, v.v1, 8'hFF, 8'hFF);
            @(negedge clk);
        end
        chk({nm, "_result"}, {b1.done, b1.done_id, b1.match_cnt, b0.match_cnt}, {1'b1, v.id, 4'(v.c1), 4'(v.c0)});
        @(posedge clk);
        #1 put(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    function automatic logic [7:0] pick();
        logic [7:0] l[5] = '{8'hD0, 8'hDB, 8'h6D, 8'hDD, 8'h0D};
        return ($urandom_range(0, 1) == 0) ? l[$urandom_range(0, 4)] : 8'($urandom);
    endfunction

    vec_t tv[8];

    initial begin
        tv[0] = '{1'b1, 1'b0, 8'hD0, 8'h00, 1'b0, 1, 1};
        tv[1] = '{1'b0, 1'b1, 8'h00, 8'hDB, 1'b1, 2, 1};
        tv[2] = '{1'b1, 1'b1, 8'h6D, 8'h00, 1'b0, 2, 1};
        tv[3] = '{1'b1, 1'b1, 8'hFF, 8'hDD, 1'b1, 2, 2};
        tv[4] = '{1'b1, 1'b1, 8'h0D, 8'hFF, 1'b0, 1, 1};
        tv[5] = '{1'b0, 1'b1, 8'h00, 8'hB4, 1'b1, 1, 1};
        tv[6] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 0, 0};
        tv[7] = '{1'b1, 1'b0, 8'hDA, 8'h00, 1'b0, 2, 1};
        put(1'b1, 1'b1, 8'h00, 8'h6D);
        #2 do_reset();
        @(negedge clk);
        chk("both_first_ready", {b1.req1_ready, b1.req0_ready}, 2'b01);
        for (int k = 1; k <= 29; k++) begin
            @(posedge clk);
            #1;
            if (k == 21) put(1'b0, 1'b0, 8'h00, 8'h00);
            @(negedge clk);
            if (k == 9 || k == 29)
                chk($sformatf("both_done_c%0d", k), {b1.done, b1.done_id, b1.match_cnt, b0.match_cnt}, {1'b1, 1'b0, 4'd0, 4'd0});
            if (k == 19)
                chk("both_done_c19", {b1.done, b1.done_id, b1.match_cnt, b0.match_cnt}, {1'b1, 1'b1, 4'd2, 4'd1});
            if (k == 10) chk("both_ready_c10", {b1.req1_ready, b1.req0_ready}, 2'b10);
            if (k == 20) chk("both_ready_c20", {b1.req1_ready, b1.req0_ready}, 2'b01);
        end
        @(posedge clk);
        #1 do_reset();
        for (int i = 0; i < 8; i++) run_one(tv[i], 1'b1, $sformatf("vec%0d", i));
        run_one(tv[0], 1'b0, "held_capture");
        run_one(tv[1], 1'b1, "pre_reset");
        put(1'b1, 1'b0, 8'hD0, 8'h00);
        @(negedge clk);
        chk("mid_grant", {b1.req1_ready, b1.req0_ready}, 2'b01);
        repeat (4) @(posedge clk);
        #1 clr = 1'b0;
        #1 chk("mid_reset_outputs", {b1.req1_ready, b1.req0_ready, b1.done, b1.done_id, b1.match_cnt, b0.match_cnt}, 0);
        @(posedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        chk("regrant", {b1.req1_ready, b1.req0_ready}, 2'b01);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1 put(1'b0, 1'b0, 8'h00, 8'h00);
            @(negedge clk);
        end
        chk("regrant_result", {b1.done, b1.done_id, b1.match_cnt, b0.match_cnt}, {1'b1, 1'b0, 4'd1, 4'd1});
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1 put($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30, pick(), pick());
        end
        @(posedge clk);
        #1 put(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
